// File: rtl/tp84_hs_ram_arbiter.sv
// Work-RAM port arbiter: the CPU owns the RAM by default. A hiscore request pauses
// the CPU, drains its bus, grants the port to the hiscore engine, and hands it back after a holdoff.
module tp84_hs_ram_arbiter #(
  parameter int AW          = 11,
  parameter int DRAIN_CYC   = 2,
  parameter int RELEASE_CYC = 4,
  parameter int RAM_LAT     = 1
) (
  input  logic          clk_49m,
  input  logic          reset,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_pause,
  input  logic          hs_access,
  input  logic [15:0]   hs_address,
  input  logic [7:0]    hs_data_in,
  input  logic          hs_write,
  output logic [7:0]    hs_data_out,
  output logic          hs_grant,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout
);

  typedef enum logic [1:0] {IDLE, DRAIN, GRANT, RELEASE} state_t;

  localparam logic [3:0] DRAIN_LAST   = 4'(DRAIN_CYC - 1);
  localparam logic [3:0] RELEASE_LAST = 4'(RELEASE_CYC - 1);

  state_t       state, state_next;
  logic [3:0]   cnt, cnt_next;
  logic [3:0]   cnt_inc;
  logic         cpu_own;
  logic [RAM_LAT-1:0] hs_vld, cpu_vld;
  logic         unused_hs_hi;

  // Address bits above the RAM size simply wrap into it.
  assign unused_hs_hi = ^hs_address[15:AW];

  assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (hs_access) begin
          state_next = DRAIN;
          cnt_next   = 4'd0;
        end
      end
      DRAIN: begin
        if (!hs_access) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt >= DRAIN_LAST) begin
          state_next = GRANT;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      GRANT: begin
        if (!hs_access) begin
          state_next = RELEASE;
          cnt_next   = 4'd0;
        end
      end
      RELEASE: begin
        // A new request here skips the drain: the CPU never resumed.
        if (hs_access) begin
          state_next = GRANT;
          cnt_next   = 4'd0;
        end else if (cnt >= RELEASE_LAST) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign cpu_pause = (state != IDLE);
  assign hs_grant  = (state == GRANT);
  assign cpu_own   = (state == IDLE) || (state == DRAIN);

  assign ram_addr = hs_grant ? hs_address[AW-1:0] : cpu_addr;
  assign ram_din  = hs_grant ? hs_data_in : cpu_din;
  assign ram_we   = hs_grant ? hs_write : (cpu_cs & cpu_we);

  // Valid pipes track which owner issued the address whose data now sits on ram_dout.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      hs_vld      <= '0;
      cpu_vld     <= '0;
      hs_data_out <= 8'h00;
      cpu_dout    <= 8'h00;
    end else begin
      hs_vld  <= RAM_LAT'({hs_vld, hs_grant});
      cpu_vld <= RAM_LAT'({cpu_vld, cpu_own});
      if (hs_vld[RAM_LAT-1]) begin
        hs_data_out <= ram_dout;
      end
      if (cpu_vld[RAM_LAT-1] && cpu_own) begin
        cpu_dout <= ram_dout;
      end
    end
  end

endmodule

// File: doc/tp84_hs_ram_arbiter.md
Name: tp84_hs_ram_arbiter

Overview:
- Shares one single-port work RAM between the main CPU and the hiscore save/restore engine.
- On a hiscore access request it pauses the CPU, waits for the CPU bus to drain, then grants the RAM port to the hiscore engine.
- When the request drops it returns the port to the CPU after a release holdoff.
- Sits inside the TimePilot84 top level, between the CPU bus decode and the RAM instance, and drives the CPU pause.

Parameters:
AW, 11, RAM address width (hiscore address uses its low AW bits).
DRAIN_CYC, 2, clocks of CPU pause before the grant; lets an in-flight CPU write complete (range 1..15).
RELEASE_CYC, 4, clocks of CPU pause held after the grant ends (range 1..15).
RAM_LAT, 1, RAM read latency in clocks (1 or 2).

Ports:
clk_49m  in  1  system clock
reset  in  1  asynchronous active-low reset
cpu_cs  in  1  CPU RAM chip select
cpu_we  in  1  CPU write strobe, qualified by cpu_cs
cpu_addr  in  AW  CPU address
cpu_din  in  8  CPU write data
cpu_dout  out  8  read data to CPU
cpu_pause  out  1  high = halt CPU clock enable
hs_access  in  1  hiscore request (read or write intent)
hs_address  in  16  hiscore address
hs_data_in  in  8  hiscore write data
hs_write  in  1  hiscore write strobe
hs_data_out  out  8  registered read data to hiscore
hs_grant  out  1  high while hiscore owns RAM
ram_addr  out  AW  RAM address
ram_din  out  8  RAM write data
ram_we  out  1  RAM write enable
ram_dout  in  8  RAM read data

Behaviour:
- Reset values: state IDLE, cpu_pause=0, hs_grant=0, hs_data_out=0, cpu_dout=0, counters=0. ram_* follow the CPU mux, so ram_we=0 while cpu_cs=0.
- Reset asserted mid-operation (any state) forces IDLE asynchronously. The CPU is un-paused on the same edge.
- States:
  - IDLE: CPU owns the RAM. hs_access=1 -> DRAIN, with cpu_pause=1 from the next clock.
  - DRAIN: cpu_pause=1; count DRAIN_CYC clocks, then -> GRANT. If hs_access drops before the count expires -> IDLE directly, cpu_pause=0 next clock, no RELEASE (CPU never lost the bus).
  - GRANT: hs_grant=1, cpu_pause=1, hiscore drives the RAM. hs_access=0 -> RELEASE.
  - RELEASE: hs_grant=0, cpu_pause=1; count RELEASE_CYC clocks, then -> IDLE. If hs_access re-asserts during RELEASE -> GRANT next clock with no new drain (CPU still halted).
- RAM mux (combinational, selected by the registered hs_grant):
  - Grant=0: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_cs&cpu_we.
  - Grant=1: ram_addr=hs_address[AW-1:0], ram_din=hs_data_in, ram_we=hs_write.
  - hs_write while not granted is ignored (no RAM write).
  - CPU writes during GRANT are blocked.
- hs_data_out: captures ram_dout RAM_LAT clocks after each address presented during GRANT, using a RAM_LAT-deep valid pipe. It holds between captures and is never updated from CPU cycles.
- cpu_dout: equals ram_dout, registered with RAM_LAT alignment, while the CPU owns the RAM. It freezes at its last value from GRANT entry until IDLE is re-entered.
- Upper hiscore address bits [15:AW] are ignored (wrap into RAM).
- Counters saturate; they never wrap.

Test Plan:
- Reset released, CPU writes 0x5A at 0x123 and reads it back -> cpu_dout=0x5A after RAM_LAT; cpu_pause=0, hs_grant=0 throughout.
- hs_access rises at clock T -> cpu_pause=1 at T+1, hs_grant=1 at T+1+DRAIN_CYC (T+3 at defaults); hiscore write 0xA5 at 0x7FF lands in RAM; CPU write to 0x7FF during GRANT does not change it.
- hs_access held 1 clock (drops in DRAIN) -> hs_grant never rises, cpu_pause back to 0 two clocks after rise, no RAM write.
- Grant ends, hs_access re-asserts 2 clocks into RELEASE -> hs_grant=1 next clock, cpu_pause stays 1 continuously.
- Hiscore read at 0x0A0 holding 0x3C -> hs_data_out=0x3C exactly RAM_LAT clocks later; cpu_dout unchanged.
- Reset asserted during GRANT -> hs_grant=0, cpu_pause=0 immediately; hs_address=0x1800 with AW=11 -> ram_addr=0x000.
